// File: rtl/ecc_dbl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_dbl_pkg                                               |
// | Purpose  : Shared types and modular helpers for Jacobian doubling    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package ecc_dbl_pkg;

    // Working width of the helpers; callers zero-extend and truncate, so
    // any field width below this carries the extra bit the linear ops need.
    localparam int c_max_w = 256;
    typedef logic [c_max_w-1:0] felem_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        S_XX   = 4'd0,
        S_YY   = 4'd1,
        S_YYYY = 4'd2,
        S_ZZ   = 4'd3,
        S_ZZZZ = 4'd4,
        S_T    = 4'd5,
        S_U    = 4'd6,
        S_V    = 4'd7,
        S_W    = 4'd8,
        S_R    = 4'd9
    } step_t;

    function automatic int lat_full(input int n);
        return 10 * n + 22;
    endfunction

    function automatic int lat_azero(input int n);
        return 8 * n + 18;
    endfunction

    function automatic felem_t mod_add(input felem_t x, input felem_t y, input felem_t m);
        felem_t s;
        s = x + y;
        if (s >= m) s = s - m;
        return s;
    endfunction

    function automatic felem_t mod_sub(input felem_t x, input felem_t y, input felem_t m);
        felem_t d;
        d = x - y;
        if (x < y) d = d + m;
        return d;
    endfunction

    function automatic felem_t mod_dbl(input felem_t x, input felem_t m);
        return mod_add(x, x, m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_point_double_jac_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_point_double_jac_if                                   |
// | Purpose  : Start/done request bus of the Jacobian point doubler      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface ecc_point_double_jac_if #(parameter int N = 231);
    logic         start;
    logic         ready;
    logic [N-1:0] p;
    logic [N-1:0] a;
    logic [N-1:0] x1;
    logic [N-1:0] y1;
    logic [N-1:0] z1;
    logic [N-1:0] x3;
    logic [N-1:0] y3;
    logic [N-1:0] z3;
    logic         done;
    logic         infinity;

    modport master (
        output start, p, a, x1, y1, z1,
        input  ready, x3, y3, z3, done, infinity
    );

    modport slave (
        input  start, p, a, x1, y1, z1,
        output ready, x3, y3, z3, done, infinity
    );
endinterface
`default_nettype wire

// File: rtl/fp_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fp_mul_seq                                                |
// | Purpose  : MSB-first interleaved shift-add modular multiplier        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fp_mul_seq
    import ecc_dbl_pkg::*;
#(
    parameter int N = 231
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] p,
    input  logic [N-1:0] a_op,
    input  logic [N-1:0] b_op,
    output logic         done,
    output logic [N-1:0] prod
);

    localparam int                 c_cnt_w    = $clog2(N);
    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(N - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [N-1:0]       r_p;
    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    function automatic logic [N-1:0] mac_step(input logic [N-1:0] acc, input logic [N-1:0] addend,
                                              input logic bit_i, input logic [N-1:0] m);
        felem_t t;
        t = mod_dbl(felem_t'(acc), felem_t'(m));
        if (bit_i) t = mod_add(t, felem_t'(addend), felem_t'(m));
        return N'(t);
    endfunction

    // The top bit is consumed on the start edge, so the last of the N bits
    // lands N-1 edges later and done shows exactly N cycles after start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_p    <= p;
                r_a    <= a_op;
                r_b    <= {b_op[N-2:0], 1'b0};
                r_acc  <= mac_step('0, a_op, b_op[N-1], p);
                r_cnt  <= c_cnt_init;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_acc <= mac_step(r_acc, r_a, r_b[N-1], r_p);
                r_b   <= {r_b[N-2:0], 1'b0};
                r_cnt <= r_cnt - c_cnt_one;
                if (r_cnt == c_cnt_one) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign prod = r_acc;

endmodule
`default_nettype wire

// File: rtl/ecc_point_double_jac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ecc_point_double_jac                                      |
// | Purpose  : Jacobian point doubling on one shared modular multiplier  |
// | Options  : ECC_DBL_AZERO_EN - skip ZZZZ and a*ZZZZ when a == 0       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ecc_point_double_jac
    import ecc_dbl_pkg::*;
#(
    parameter int N = 231
)
(
    input  logic clk,
    input  logic reset,
    ecc_point_double_jac_if.slave bus
);

    localparam int                 c_cyc_w    = $clog2(N + 2);
    localparam logic [c_cyc_w-1:0] c_cyc_zero = '0;
    localparam logic [c_cyc_w-1:0] c_cyc_one  = c_cyc_w'(1);
    localparam logic [c_cyc_w-1:0] c_cyc_wb   = c_cyc_w'(N + 1);
    localparam logic [3:0]         c_step_one = 4'd1;
    localparam logic [N-1:0]       c_zero     = '0;
    localparam logic [N-1:0]       c_one      = N'(1);

    state_t             r_state;
    step_t              r_step;
    step_t              w_next_step;
    logic [c_cyc_w-1:0] r_cyc;
    logic               r_ready;
    logic               r_done;
    logic               r_inf;
    logic [N-1:0]       r_ox3, r_oy3, r_oz3;

    logic [N-1:0] r_p, r_a, r_x1, r_y1, r_z1;
    logic [N-1:0] r_xx, r_yy, r_yyyy, r_zz, r_zzzz, r_m, r_s, r_x3, r_y3, r_prod;
    logic [N-1:0] w_op_a, w_op_b, w_wb, w_xx3, w_mul_prod;
    logic         w_mul_start, w_mul_done, w_wb_en, w_accept;
`ifdef ECC_DBL_AZERO_EN
    logic         r_azero;
`endif

    function automatic logic [N-1:0] f_add(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
        return N'(mod_add(felem_t'(x), felem_t'(y), felem_t'(m)));
    endfunction

    function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N-1:0] m);
        return N'(mod_sub(felem_t'(x), felem_t'(y), felem_t'(m)));
    endfunction

    function automatic logic [N-1:0] f_dbl(input logic [N-1:0] x, input logic [N-1:0] m);
        return N'(mod_dbl(felem_t'(x), felem_t'(m)));
    endfunction

    assign w_accept    = (r_state == ST_IDLE) && bus.start;
    assign w_mul_start = (r_state == ST_MUL) && (r_cyc == c_cyc_zero);
    assign w_wb_en     = (r_state == ST_MUL) && (r_cyc == c_cyc_wb);

`ifdef ECC_DBL_AZERO_EN
    assign w_next_step = (r_azero && (r_step == S_ZZ)) ? S_U : step_t'(r_step + c_step_one);
`else
    assign w_next_step = step_t'(r_step + c_step_one);
`endif

    // Operand select for the issue cycle and the linear op folded into writeback.
    always_comb begin
        w_op_a = r_x1;
        w_op_b = r_x1;
        w_wb   = r_prod;
        w_xx3  = f_add(f_dbl(r_xx, r_p), r_xx, r_p);
        case (r_step)
            S_YY:   begin w_op_a = r_y1;   w_op_b = r_y1;   end
            S_YYYY: begin w_op_a = r_yy;   w_op_b = r_yy;   end
            S_ZZ:   begin w_op_a = r_z1;   w_op_b = r_z1;   end
            S_ZZZZ: begin w_op_a = r_zz;   w_op_b = r_zz;   end
            S_T: begin
                w_op_a = r_a;
                w_op_b = r_zzzz;
                w_wb   = f_add(w_xx3, r_prod, r_p);
            end
            S_U: begin
                w_op_a = r_x1;
                w_op_b = r_yy;
                w_wb   = f_dbl(f_dbl(r_prod, r_p), r_p);
            end
            S_V: begin
                w_op_a = r_m;
                w_op_b = r_m;
                w_wb   = f_sub(r_prod, f_dbl(r_s, r_p), r_p);
            end
            S_W: begin
                w_op_a = r_m;
                w_op_b = f_sub(r_s, r_x3, r_p);
                w_wb   = f_sub(r_prod, f_dbl(f_dbl(f_dbl(r_yyyy, r_p), r_p), r_p), r_p);
            end
            S_R: begin
                w_op_a = r_y1;
                w_op_b = r_z1;
                w_wb   = f_dbl(r_prod, r_p);
            end
            default: ;
        endcase
    end

    fp_mul_seq #(.N(N)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (w_mul_start),
        .p     (r_p),
        .a_op  (w_op_a),
        .b_op  (w_op_b),
        .done  (w_mul_done),
        .prod  (w_mul_prod)
    );

    // Datapath registers carry no reset: every one is written before it is read.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_p  <= bus.p;
            r_a  <= bus.a;
            r_x1 <= bus.x1;
            r_y1 <= bus.y1;
            r_z1 <= bus.z1;
`ifdef ECC_DBL_AZERO_EN
            r_azero <= (bus.a == c_zero);
`endif
        end
        if (w_mul_done) r_prod <= w_mul_prod;
        if (w_wb_en) begin
            case (r_step)
                S_XX:   r_xx   <= w_wb;
                S_YY:   r_yy   <= w_wb;
                S_YYYY: r_yyyy <= w_wb;
                S_ZZ: begin
                    r_zz <= w_wb;
`ifdef ECC_DBL_AZERO_EN
                    if (r_azero) r_m <= w_xx3;
`endif
                end
                S_ZZZZ: r_zzzz <= w_wb;
                S_T:    r_m    <= w_wb;
                S_U:    r_s    <= w_wb;
                S_V:    r_x3   <= w_wb;
                S_W:    r_y3   <= w_wb;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_step  <= S_XX;
            r_cyc   <= c_cyc_zero;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_inf   <= 1'b0;
            r_ox3   <= c_zero;
            r_oy3   <= c_zero;
            r_oz3   <= c_zero;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_LOAD;
                        r_ready <= 1'b0;
                        r_inf   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_step <= S_XX;
                    r_cyc  <= c_cyc_zero;
                    if ((r_z1 == c_zero) || (r_y1 == c_zero)) begin
                        r_state <= ST_FIN;
                        r_done  <= 1'b1;
                        r_inf   <= 1'b1;
                        r_ox3   <= c_one;
                        r_oy3   <= c_one;
                        r_oz3   <= c_zero;
                    end else begin
                        r_state <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (r_cyc == c_cyc_wb) begin
                        r_cyc <= c_cyc_zero;
                        if (r_step == S_R) begin
                            r_state <= ST_FIN;
                            r_done  <= 1'b1;
                            r_ox3   <= r_x3;
                            r_oy3   <= r_y3;
                            r_oz3   <= w_wb;
                        end else begin
                            r_step <= w_next_step;
                        end
                    end else begin
                        r_cyc <= r_cyc + c_cyc_one;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.infinity = r_inf;
    assign bus.x3       = r_ox3;
    assign bus.y3       = r_oy3;
    assign bus.z3       = r_oz3;

endmodule
`default_nettype wire

// File: tb/tb_ecc_point_double_jac.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ecc_point_double_jac                                   |
// | Purpose  : Randomised self-checking bench for the Jacobian doubler   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_ecc_point_double_jac;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   primes[8] = '{251, 241, 233, 199, 131, 101, 17, 13};

    always #5 clk = ~clk;

    ecc_point_double_jac_if #(.N(N)) bus ();

    ecc_point_double_jac #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int md(input int v, input int m);
        int r;
        r = v % m;
        if (r < 0) r = r + m;
        return r;
    endfunction

    // Textbook doubling formulas evaluated with ordinary integers.
    function automatic void ref_dbl(input int p, input int a, input int x, input int y, input int z,
                                    output int ex, output int ey, output int ez, output bit einf);
        int xx, yy, yyyy, zz, m, s;
        if (y == 0 || z == 0) begin
            ex = 1; ey = 1; ez = 0; einf = 1'b1;
        end else begin
            xx   = md(x * x, p);
            yy   = md(y * y, p);
            yyyy = md(yy * yy, p);
            zz   = md(z * z, p);
            m    = md(3 * xx + a * md(zz * zz, p), p);
            s    = md(4 * x * yy, p);
            ex   = md(m * m - 2 * s, p);
            ey   = md(m * md(s - ex, p) - 8 * yyyy, p);
            ez   = md(2 * y * z, p);
            einf = 1'b0;
        end
    endfunction

    function automatic int exp_lat(input int a, input bit inf);
        if (inf) return 2;
`ifdef ECC_DBL_AZERO_EN
        if (a == 0) return 8 * N + 18;
`endif
        return 10 * N + 22;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inputs(input int p, input int a, input int x, input int y, input int z);
        bus.p  = N'(p);
        bus.a  = N'(a);
        bus.x1 = N'(x);
        bus.y1 = N'(y);
        bus.z1 = N'(z);
    endtask

    // Waits (bounded) for ready, issues one start, then scrambles the inputs.
    task automatic drive_start(input int p, input int a, input int x, input int y, input int z);
        int k;
        k = 0;
        while (bus.ready !== 1'b1 && k < 500) begin
            step();
            k++;
        end
        set_inputs(p, a, x, y, z);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom);
    endtask

    task automatic wait_done(input int from, output int lat, output bit ok);
        lat = from;
        while (bus.done !== 1'b1 && lat < 600) begin
            step();
            lat++;
        end
        ok = (bus.done === 1'b1);
    endtask

    task automatic rand_vec(output int p, output int a, output int x, output int y, output int z);
        p = primes[$urandom_range(7, 0)];
        a = int'($urandom_range(p - 1, 0));
        x = int'($urandom_range(p - 1, 0));
        y = int'($urandom_range(p - 1, 1));
        z = int'($urandom_range(p - 1, 1));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        set_inputs(0, 0, 0, 0, 0);
        repeat (3) step();
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL reset ready: got %b want 1", bus.ready); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.infinity !== 1'b0) $display("FAIL reset infinity: got %b want 0", bus.infinity); else n_pass++;
        n_checks++; if (bus.x3 !== 8'd0) $display("FAIL reset x3: got %0d want 0", bus.x3); else n_pass++;
        n_checks++; if (bus.y3 !== 8'd0) $display("FAIL reset y3: got %0d want 0", bus.y3); else n_pass++;
        n_checks++; if (bus.z3 !== 8'd0) $display("FAIL reset z3: got %0d want 0", bus.z3); else n_pass++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_directed();
        int lat;
        bit ok;
        drive_start(17, 2, 5, 1, 1);
        wait_done(1, lat, ok);
        n_checks++; if (!ok || lat != 102) $display("FAIL dir1 latency: got %0d (done %b) want 102", lat, ok); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'd7, 8'd7, 8'd2}) $display("FAIL dir1 result: got (%0d,%0d,%0d) want (7,7,2)", bus.x3, bus.y3, bus.z3); else n_pass++;
        n_checks++; if (bus.infinity !== 1'b0) $display("FAIL dir1 infinity: got %b want 0", bus.infinity); else n_pass++;
        step();
        n_checks++; if (bus.done !== 1'b0 || bus.ready !== 1'b1) $display("FAIL dir1 after FIN: got done=%b ready=%b want done=0 ready=1", bus.done, bus.ready); else n_pass++;
        drive_start(17, 0, 1, 5, 1);
        wait_done(1, lat, ok);
        n_checks++; if (!ok || lat != exp_lat(0, 1'b0)) $display("FAIL dir2 latency: got %0d (done %b) want %0d", lat, ok, exp_lat(0, 1'b0)); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'd13, 8'd4, 8'd10}) $display("FAIL dir2 result: got (%0d,%0d,%0d) want (13,4,10)", bus.x3, bus.y3, bus.z3); else n_pass++;
        step();
    endtask

    task automatic test_infinity();
        int p, a, x, y, z, lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            rand_vec(p, a, x, y, z);
            if (i % 2 == 0) y = 0; else z = 0;
            drive_start(p, a, x, y, z);
            wait_done(1, lat, ok);
            n_checks++; if (!ok || lat != 2) $display("FAIL inf%0d latency: got %0d (done %b) want 2", i, lat, ok); else n_pass++;
            n_checks++; if (bus.infinity !== 1'b1) $display("FAIL inf%0d flag: got %b want 1", i, bus.infinity); else n_pass++;
            n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'd1, 8'd1, 8'd0}) $display("FAIL inf%0d result: got (%0d,%0d,%0d) want (1,1,0)", i, bus.x3, bus.y3, bus.z3); else n_pass++;
            repeat (3) step();
            n_checks++; if (bus.infinity !== 1'b1 || bus.z3 !== 8'd0) $display("FAIL inf%0d hold: got inf=%b z3=%0d want inf=1 z3=0", i, bus.infinity, bus.z3); else n_pass++;
        end
    endtask

    task automatic test_random();
        int p, a, x, y, z, ex, ey, ez, lat;
        bit einf, ok;
        for (int i = 0; i < 10; i++) begin
            rand_vec(p, a, x, y, z);
            if (i == 3) a = 0;
            ref_dbl(p, a, x, y, z, ex, ey, ez, einf);
            drive_start(p, a, x, y, z);
            wait_done(1, lat, ok);
            n_checks++; if (!ok || lat != exp_lat(a, einf)) $display("FAIL rand%0d latency: got %0d (done %b) want %0d", i, lat, ok, exp_lat(a, einf)); else n_pass++;
            n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'(ex), 8'(ey), 8'(ez)}) $display("FAIL rand%0d result p=%0d a=%0d (%0d,%0d,%0d): got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, p, a, x, y, z, bus.x3, bus.y3, bus.z3, ex, ey, ez); else n_pass++;
            n_checks++; if (bus.infinity !== einf) $display("FAIL rand%0d infinity: got %b want %b", i, bus.infinity, einf); else n_pass++;
            step();
        end
    endtask

    task automatic test_start_ignored();
        int lat, pulses;
        bit ok;
        drive_start(17, 2, 5, 1, 1);
        repeat (30) step();
        set_inputs(17, 0, 1, 5, 1);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(32, lat, ok);
        n_checks++; if (!ok || lat != 102) $display("FAIL ignore latency: got %0d (done %b) want 102", lat, ok); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'd7, 8'd7, 8'd2}) $display("FAIL ignore result: got (%0d,%0d,%0d) want (7,7,2)", bus.x3, bus.y3, bus.z3); else n_pass++;
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL ignore extra done: got %0d pulses want 0", pulses); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int p, a, x, y, z, ex, ey, ez, lat, pulses;
        bit einf, ok;
        rand_vec(p, a, x, y, z);
        drive_start(p, a, x, y, z);
        repeat (40) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) $display("FAIL abort control: got ready=%b done=%b want 1/0", bus.ready, bus.done); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== 24'd0 || bus.infinity !== 1'b0) $display("FAIL abort outputs: got (%0d,%0d,%0d) inf=%b want zeros", bus.x3, bus.y3, bus.z3, bus.infinity); else n_pass++;
        pulses = 0;
        for (int k = 0; k < 120; k++) begin
            if (bus.done === 1'b1) pulses++;
            step();
        end
        n_checks++; if (pulses != 0) $display("FAIL abort done pulses: got %0d want 0", pulses); else n_pass++;
        rand_vec(p, a, x, y, z);
        ref_dbl(p, a, x, y, z, ex, ey, ez, einf);
        drive_start(p, a, x, y, z);
        wait_done(1, lat, ok);
        n_checks++; if (!ok || lat != exp_lat(a, einf)) $display("FAIL post-abort latency: got %0d (done %b) want %0d", lat, ok, exp_lat(a, einf)); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'(ex), 8'(ey), 8'(ez)}) $display("FAIL post-abort result: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", bus.x3, bus.y3, bus.z3, ex, ey, ez); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        int p, a, x, y, z, ex, ey, ez, lat, unstable;
        bit einf, ok;
        logic [3*N-1:0] first;
        rand_vec(p, a, x, y, z);
        ref_dbl(p, a, x, y, z, ex, ey, ez, einf);
        drive_start(p, a, x, y, z);
        wait_done(1, lat, ok);
        first = {bus.x3, bus.y3, bus.z3};
        n_checks++; if (!ok || first !== {8'(ex), 8'(ey), 8'(ez)}) $display("FAIL b2b first: got (%0d,%0d,%0d) done %b want (%0d,%0d,%0d)", bus.x3, bus.y3, bus.z3, ok, ex, ey, ez); else n_pass++;
        // start raised in FIN with an infinity vector: must not be taken
        set_inputs(17, 2, 3, 0, 4);
        bus.start = 1'b1;
        step();
        n_checks++; if (bus.ready !== 1'b1) $display("FAIL b2b start in FIN: got ready=%b want 1", bus.ready); else n_pass++;
        set_inputs(17, 2, 5, 1, 1);
        step();
        bus.start = 1'b0;
        set_inputs($urandom, $urandom, $urandom, $urandom, $urandom);
        unstable = 0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 600) begin
            if ({bus.x3, bus.y3, bus.z3} !== first) unstable++;
            step();
            lat++;
        end
        n_checks++; if (unstable != 0) $display("FAIL b2b hold: got %0d changed cycles want 0", unstable); else n_pass++;
        n_checks++; if (lat != 102) $display("FAIL b2b second latency: got %0d want 102", lat); else n_pass++;
        n_checks++; if ({bus.x3, bus.y3, bus.z3} !== {8'd7, 8'd7, 8'd2}) $display("FAIL b2b second result: got (%0d,%0d,%0d) want (7,7,2)", bus.x3, bus.y3, bus.z3); else n_pass++;
        step();
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_directed();
        test_infinity();
        test_random();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ecc_point_double_jac.md
Name: ecc_point_double_jac

Overview:
- Parametrised point doubling over a prime field, y^2 = x^3 + a*x + b, in Jacobian coordinates (X:Y:Z), so no modular inversion is needed.
- One shared sequential modular multiplier is driven by a fixed micro-sequence. Linear ops (add, sub, small-constant multiply mod p) are folded into multiplier writeback.
- Start/done handshake with fixed, deterministic latency. Sits under the scalar-multiplication controller next to the point-addition block.

Parameters:
- N, 231, field element width in bits. Requires p < 2^N and N >= 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle request; accepted only when ready=1
- ready  out  1  high in IDLE
- p  in  N  field prime; sampled at start
- a  in  N  curve coefficient, < p; sampled at start
- x1, y1, z1  in  N  input point, each < p; sampled at start
- x3, y3, z3  out  N  result; z3=0 means point at infinity
- done  out  1  one-cycle pulse when x3/y3/z3 are valid
- infinity  out  1  result is the point at infinity; valid with done, held until next start

Behaviour:
- Reset value: ready=1, done=0, infinity=0, x3=y3=z3=0; FSM goes to IDLE.
- Reset is a synchronous abort from any state. The multiplier is reset too; no done is produced for an aborted operation.
- States and transitions:
  - IDLE -> LOAD on start.
  - LOAD -> MUL, or LOAD -> FIN if (z1==0 || y1==0).
  - MUL(k), k=0..K-1, each step exactly N+2 cycles (issue, N multiplier cycles, writeback).
  - FIN -> IDLE. done=1 is asserted during FIN.
- LOAD latches p, a, x1, y1, z1. start seen while not ready is ignored; inputs may change freely after acceptance.
- Micro-sequence (all values mod p), K=10:
  - XX=X1^2; YY=Y1^2; YYYY=YY^2; ZZ=Z1^2; ZZZZ=ZZ^2
  - T=a*ZZZZ; writeback M=3*XX+T
  - U=X1*YY; writeback S=4*U
  - V=M^2; writeback X3=V-2S
  - W=M*(S-X3); writeback Y3=W-8*YYYY
  - R=Y1*Z1; writeback Z3=2R
- Linear reduction:
  - add: conditional subtract of p.
  - sub: conditional add of p.
  - 2x, 4x, 8x: chained doublings.
  - 3x: double plus add.
  - All intermediates are N+1 bits before reduction. Results are always in [0, p).
- Latency, start-accept edge to done=1:
  - LAT = 1 + K*(N+2) + 1 = 10N+22 cycles.
  - Infinity path: LAT = 2.
- Infinity path: x3=1, y3=1, z3=0, infinity=1.
- Outputs are updated only in FIN and are held stable until the next FIN.
- start asserted in the same cycle as done (FIN) is not accepted; ready rises the cycle after FIN.
- Inputs >= p are undefined.

Optional Feature:
- Macro: ECC_DBL_AZERO_EN.
- Defined: LOAD checks a==0; if true, the ZZZZ and T steps are skipped and M=3*XX. In that case K=8 and LAT=8N+18. Otherwise LAT is 10N+22.
- Undefined: always K=10, and a==0 is processed through the general path with an identical result.

Decomposition:
- Package ecc_dbl_pkg holds:
  - state enum (IDLE, LOAD, MUL, FIN)
  - micro-step index enum
  - functions lat_full(N)=10N+22 and lat_azero(N)=8N+18
  - mod-add/mod-sub/mod-double functions
- Sub-module fp_mul_seq #(N): interleaved shift-add modular multiplier.
  - Ports: clk, reset, start, p, a_op, b_op, done, prod.
  - done asserted exactly N cycles after start; prod valid with done.

Test Plan:
- N=8, p=17, a=2, (x1,y1,z1)=(5,1,1), start -> done exactly 102 cycles later; (x3,y3,z3)=(7,7,2), infinity=0 (affine (6,3)).
- N=8, p=17, a=0, (1,5,1) -> (13,4,10). Without the macro, done at 102 cycles; with ECC_DBL_AZERO_EN, done at 82 cycles.
- y1=0, or z1=0 with any x -> done 2 cycles after start; infinity=1, z3=0.
- start pulsed mid-MUL with different inputs -> ignored; the first result and latency are unchanged.
- reset asserted mid-MUL -> next cycle ready=1, outputs 0, no done pulse. A new start then gives a correct result.
- Back-to-back: start on the cycle after FIN with the first vector -> two correct done pulses. Outputs are stable between them.
